// File: rtl/arb2_if.sv
// Command, arbiter and beat signals between arb2_requester and its environment.
// master is the requester side; slave is the client/arbiter side.
interface arb2_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 4
);
    logic          push1;
    logic          push2;
    logic [DW-1:0] push_data1;
    logic [DW-1:0] push_data2;
    logic [LW-1:0] push_len1;
    logic [LW-1:0] push_len2;
    logic          full1;
    logic          full2;
    logic          req1;
    logic          req2;
    logic          gnt1;
    logic          gnt2;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          done1;
    logic          done2;
    logic          starve1;
    logic          starve2;
    logic          proto_err;
    logic          clr_flags;

    modport master (
        input  push1, push2, push_data1, push_data2, push_len1, push_len2,
        input  gnt1, gnt2, clr_flags,
        output full1, full2, req1, req2, out_valid, out_data, out_src,
        output done1, done2, starve1, starve2, proto_err
    );

    modport slave (
        output push1, push2, push_data1, push_data2, push_len1, push_len2,
        output gnt1, gnt2, clr_flags,
        input  full1, full2, req1, req2, out_valid, out_data, out_src,
        input  done1, done2, starve1, starve2, proto_err
    );
endinterface

// File: rtl/arb2_requester.sv
// Requester agent for a two-way arbiter: per-channel command FIFOs, burst beat
// generation on grant, completion pulses, starvation and protocol-error flags.
module arb2_requester #(
    parameter int unsigned DW       = 8,
    parameter int unsigned LW       = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic   clk,
    input  logic   rst,
    arb2_if.master bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 8;

    logic [DW-1:0] mem_data_q [2][DEPTH];
    logic [DW-1:0] mem_data_d [2][DEPTH];
    logic [LW-1:0] mem_len_q  [2][DEPTH];
    logic [LW-1:0] mem_len_d  [2][DEPTH];
    logic [AW-1:0] rd_ptr_q [2], rd_ptr_d [2];
    logic [AW-1:0] wr_ptr_q [2], wr_ptr_d [2];
    logic [CW-1:0] count_q  [2], count_d  [2];
    logic [LW-1:0] bc_q     [2], bc_d     [2];
    logic [SW-1:0] wait_q   [2], wait_d   [2];
    logic          req_q    [2], req_d    [2];
    logic          full_q   [2], full_d   [2];
    logic          done_q   [2], done_d   [2];
    logic          starve_q [2], starve_d [2];
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_src_q, out_src_d;
    logic          proto_err_q, proto_err_d;

    logic          push_c    [2];
    logic [DW-1:0] pdata_c   [2];
    logic [LW-1:0] plen_c    [2];
    logic          gnt_c     [2];
    logic          valid_c   [2];
    logic          serve_c   [2];
    logic          pop_c     [2];
    logic          push_ok_c [2];
    logic          proto_c;

    assign push_c[0]  = bus.push1;
    assign push_c[1]  = bus.push2;
    assign pdata_c[0] = bus.push_data1;
    assign pdata_c[1] = bus.push_data2;
    assign plen_c[0]  = bus.push_len1;
    assign plen_c[1]  = bus.push_len2;
    assign gnt_c[0]   = bus.gnt1;
    assign gnt_c[1]   = bus.gnt2;

    // Next-state: arbitration outcome, FIFO update, beat, counters and flags
    always_comb begin
        mem_data_d  = mem_data_q;
        mem_len_d   = mem_len_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        bc_d        = bc_q;
        wait_d      = wait_q;
        req_d       = req_q;
        full_d      = full_q;
        done_d      = done_q;
        starve_d    = starve_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = 1'b0;
        proto_err_d = proto_err_q;

        for (int i = 0; i < 2; i++) begin
            valid_c[i] = req_q[i] & gnt_c[i];
        end
        // Channel 1 wins a double grant; channel 2 is held off
        serve_c[0] = valid_c[0];
        serve_c[1] = valid_c[1] & ~valid_c[0];
        proto_c    = (valid_c[0] & valid_c[1]) | (gnt_c[0] & ~req_q[0])
                   | (gnt_c[1] & ~req_q[1]);

        for (int i = 0; i < 2; i++) begin
            pop_c[i]     = serve_c[i] && (bc_q[i] == mem_len_q[i][rd_ptr_q[i]]);
            push_ok_c[i] = push_c[i] & ~full_q[i];
            done_d[i]    = pop_c[i];

            if (serve_c[i]) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_data_q[i][rd_ptr_q[i]] + DW'(bc_q[i]);
                out_src_d   = 1'(i);
                bc_d[i]     = pop_c[i] ? '0 : bc_q[i] + LW'(1);
            end
            if (pop_c[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            end
            if (push_ok_c[i]) begin
                mem_data_d[i][wr_ptr_q[i]] = pdata_c[i];
                mem_len_d[i][wr_ptr_q[i]]  = plen_c[i];
                wr_ptr_d[i]                = wr_ptr_q[i] + AW'(1);
            end

            count_d[i] = count_q[i] + CW'(push_ok_c[i]) - CW'(pop_c[i]);
            req_d[i]   = (count_d[i] != '0);
            full_d[i]  = (count_d[i] == CW'(DEPTH));

            if (!req_q[i] || valid_c[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] < SW'(WAIT_MAX)) begin
                wait_d[i] = wait_q[i] + SW'(1);
            end
            starve_d[i] = bus.clr_flags ? 1'b0
                        : (starve_q[i] | (wait_d[i] == SW'(WAIT_MAX)));
        end

        proto_err_d = bus.clr_flags ? 1'b0 : (proto_err_q | proto_c);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    mem_data_q[i][j] <= '0;
                    mem_len_q[i][j]  <= '0;
                end
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                bc_q[i]     <= '0;
                wait_q[i]   <= '0;
                req_q[i]    <= 1'b0;
                full_q[i]   <= 1'b0;
                done_q[i]   <= 1'b0;
                starve_q[i] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            mem_data_q  <= mem_data_d;
            mem_len_q   <= mem_len_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            bc_q        <= bc_d;
            wait_q      <= wait_d;
            req_q       <= req_d;
            full_q      <= full_d;
            done_q      <= done_d;
            starve_q    <= starve_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.req1      = req_q[0];
    assign bus.req2      = req_q[1];
    assign bus.full1     = full_q[0];
    assign bus.full2     = full_q[1];
    assign bus.done1     = done_q[0];
    assign bus.done2     = done_q[1];
    assign bus.starve1   = starve_q[0];
    assign bus.starve2   = starve_q[1];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.proto_err = proto_err_q;
endmodule
